// File: rtl/icache_responder.sv
// Direct-mapped read-only I-cache: 0-cycle hits; a miss is a blocking one-word refill, hit on the cycle after iwait drops.
// Optional hit/miss statistics counters are enabled by defining ICACHE_STATS_EN.
module icache_responder #(
   parameter int NSETS = 16
) (
   input  logic        CLK,
   input  logic        RST,
   input  logic        imemREN,
   input  logic [31:0] imemaddr,
   output logic        ihit,
   output logic [31:0] imemload,
   output logic        iREN,
   output logic [31:0] iaddr,
   input  logic        iwait,
   input  logic [31:0] iload
`ifdef ICACHE_STATS_EN
   ,
   output logic [31:0] hit_count,
   output logic [31:0] miss_count
`endif
);

   localparam int IDX  = $clog2(NSETS);
   localparam int TAGW = 32 - IDX - 2;

   typedef enum logic {S_IDLE, S_FETCH} state_t;

   state_t            r_state;
   logic [NSETS-1:0]  r_valid;
   logic [TAGW-1:0]   r_tag  [NSETS];
   logic [31:0]       r_data [NSETS];
   logic              r_iren;
   logic [31:0]       r_iaddr;

   logic [IDX-1:0]    w_idx;
   logic [TAGW-1:0]   w_tag;
   logic [IDX-1:0]    w_fill_idx;
   logic [TAGW-1:0]   w_fill_tag;
   logic              w_hit;
   logic              w_fill;
   logic              w_unused_ok;

   assign w_idx       = imemaddr[IDX+1:2];
   assign w_tag       = imemaddr[31:IDX+2];
   // r_iaddr doubles as the latched miss address while in FETCH
   assign w_fill_idx  = r_iaddr[IDX+1:2];
   assign w_fill_tag  = r_iaddr[31:IDX+2];
   assign w_unused_ok = &{1'b0, imemaddr[1:0]};

   assign w_hit  = (r_state == S_IDLE) && imemREN && r_valid[w_idx] && (r_tag[w_idx] == w_tag);
   assign w_fill = (r_state == S_FETCH) && !iwait && !RST;

   assign ihit     = w_hit;
   assign imemload = w_hit ? r_data[w_idx] : 32'd0;
   assign iREN     = r_iren;
   assign iaddr    = r_iaddr;

   always_ff @(posedge CLK) begin
      if (RST) begin
         r_state <= S_IDLE;
         r_valid <= '0;
         r_iren  <= 1'b0;
         r_iaddr <= 32'd0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (imemREN && !w_hit) begin
                  r_state <= S_FETCH;
                  r_iren  <= 1'b1;
                  r_iaddr <= {imemaddr[31:2], 2'b00};
               end
            end
            S_FETCH: begin
               if (!iwait) begin
                  r_state             <= S_IDLE;
                  r_valid[w_fill_idx] <= 1'b1;
                  r_iren              <= 1'b0;
                  r_iaddr             <= 32'd0;
               end
            end
            default: begin
               r_state <= S_IDLE;
               r_iren  <= 1'b0;
               r_iaddr <= 32'd0;
            end
         endcase
      end
   end

   // Tag/data arrays carry no reset; the valid bits alone qualify them.
   always_ff @(posedge CLK) begin
      if (w_fill) begin
         r_tag[w_fill_idx]  <= w_fill_tag;
         r_data[w_fill_idx] <= iload;
      end
   end

`ifdef ICACHE_STATS_EN
   logic [31:0] r_hit_count;
   logic [31:0] r_miss_count;

   always_ff @(posedge CLK) begin
      if (RST) begin
         r_hit_count  <= 32'd0;
         r_miss_count <= 32'd0;
      end else begin
         if (w_hit)
            r_hit_count <= r_hit_count + 32'd1;
         if ((r_state == S_IDLE) && imemREN && !w_hit)
            r_miss_count <= r_miss_count + 32'd1;
      end
   end

   assign hit_count  = r_hit_count;
   assign miss_count = r_miss_count;
`endif

endmodule

// File: tb/tb_icache_responder.sv
// Directed bench for icache_responder; expected instruction words go through a scoreboard queue.
module tb_icache_responder;

   logic        CLK = 1'b0;
   logic        RST;
   logic        imemREN;
   logic [31:0] imemaddr;
   logic        ihit;
   logic [31:0] imemload;
   logic        iREN;
   logic [31:0] iaddr;
   logic        iwait;
   logic [31:0] iload;
`ifdef ICACHE_STATS_EN
   logic [31:0] hit_count;
   logic [31:0] miss_count;
`endif

   int          total = 0;
   int          bad = 0;
   int          exp_hits = 0;
   int          exp_misses = 0;
   logic [31:0] exp_q [$];

   icache_responder #(.NSETS(16)) dut (
      .CLK(CLK),
      .RST(RST),
      .imemREN(imemREN),
      .imemaddr(imemaddr),
      .ihit(ihit),
      .imemload(imemload),
      .iREN(iREN),
      .iaddr(iaddr),
      .iwait(iwait),
      .iload(iload)
`ifdef ICACHE_STATS_EN
      ,
      .hit_count(hit_count),
      .miss_count(miss_count)
`endif
   );

   always #5 CLK = ~CLK;

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      if (a == 32'h0000_0040)
         return 32'h2001_0005;
      return {a[15:0], ~a[31:16]} ^ 32'h1357_9BDF;
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Inputs change 1 time unit after the rising edge; outputs are sampled at the falling edge.
   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   task automatic check_counts(input string tag);
      tick();
      imemREN = 1'b0;
      #4;
`ifdef ICACHE_STATS_EN
      chk({tag, "_hit_count"}, hit_count, 32'(exp_hits));
      chk({tag, "_miss_count"}, miss_count, 32'(exp_misses));
`else
      chk({tag, "_idle_iren"}, 32'(iREN), 32'd0);
`endif
   endtask

   task automatic access(input logic [31:0] a, input int nwait, input bit miss);
      tick();
      imemREN  = 1'b1;
      imemaddr = a;
      iwait    = 1'b1;
      iload    = 32'hDEAD_BEEF;
      exp_q.push_back(mem_word({a[31:2], 2'b00}));
      #4;
      if (miss) begin
         chk("miss_ihit", 32'(ihit), 32'd0);
         chk("miss_iren", 32'(iREN), 32'd0);
         exp_misses++;
         for (int k = 0; k <= nwait; k++) begin
            tick();
            iwait = (k < nwait);
            iload = (k == nwait) ? mem_word({a[31:2], 2'b00}) : 32'hDEAD_BEEF;
            #4;
            chk("fetch_iren", 32'(iREN), 32'd1);
            chk("fetch_iaddr", iaddr, {a[31:2], 2'b00});
            chk("fetch_ihit", 32'(ihit), 32'd0);
         end
         tick();
         iwait = 1'b1;
         iload = 32'hDEAD_BEEF;
         #4;
      end
      chk("hit_ihit", 32'(ihit), 32'd1);
      chk("hit_iren", 32'(iREN), 32'd0);
      chk("hit_data", imemload, exp_q.pop_front());
      exp_hits++;
   endtask

   initial begin
      RST      = 1'b1;
      imemREN  = 1'b0;
      imemaddr = 32'd0;
      iwait    = 1'b1;
      iload    = 32'd0;
      repeat (2) @(posedge CLK);
      #5;
      chk("rst_ihit", 32'(ihit), 32'd0);
      chk("rst_imemload", imemload, 32'd0);
      chk("rst_iren", 32'(iREN), 32'd0);
      chk("rst_iaddr", iaddr, 32'd0);
`ifdef ICACHE_STATS_EN
      chk("rst_hit_count", hit_count, 32'd0);
      chk("rst_miss_count", miss_count, 32'd0);
`endif
      tick();
      RST = 1'b0;

      // cold miss with 3 wait cycles, then back-to-back hits
      access(32'h0000_0040, 3, 1'b1);
      for (int i = 0; i < 4; i++)
         access(32'h0000_0040, 0, 1'b0);
      check_counts("hits");

      // conflict eviction on index 0
      access(32'h0000_0000, 1, 1'b1);
      access(32'h0000_0040, 2, 1'b1);
      access(32'h0000_0000, 0, 1'b1);
      check_counts("conflict");

      // zero-wait refills; tags differing only in bit 31 must not alias
      access(32'hFFFF_FFFC, 0, 1'b1);
      access(32'h7FFF_FFFC, 0, 1'b1);
      access(32'hFFFF_FFFC, 0, 1'b1);
      access(32'hFFFF_FFFF, 0, 1'b0);
      check_counts("zero_wait");

      // address changes while a refill of 0x80 is outstanding
      tick();
      imemREN  = 1'b1;
      imemaddr = 32'h0000_0080;
      iwait    = 1'b1;
      #4;
      chk("mid_miss_ihit", 32'(ihit), 32'd0);
      exp_misses++;
      tick();
      imemaddr = 32'hFFFF_FFFC;
      #4;
      chk("mid_fetch_nohit", 32'(ihit), 32'd0);
      chk("mid_fetch_iaddr0", iaddr, 32'h0000_0080);
      tick();
      imemaddr = 32'h0000_0084;
      #4;
      chk("mid_fetch_iaddr1", iaddr, 32'h0000_0080);
      tick();
      iwait = 1'b0;
      iload = mem_word(32'h0000_0080);
      #4;
      chk("mid_fetch_iaddr2", iaddr, 32'h0000_0080);
      chk("mid_fetch_iren", 32'(iREN), 32'd1);
      access(32'h0000_0084, 1, 1'b1);
      access(32'h0000_0080, 0, 1'b0);
      access(32'hFFFF_FFFC, 0, 1'b0);
      check_counts("mid_fetch");

      // reset during a stalled refill
      tick();
      imemREN  = 1'b1;
      imemaddr = 32'h0000_0100;
      iwait    = 1'b1;
      #4;
      chk("rstmid_miss_ihit", 32'(ihit), 32'd0);
      tick();
      #4;
      chk("rstmid_fetch_iren", 32'(iREN), 32'd1);
      tick();
      RST = 1'b1;
      #4;
      chk("rstmid_still_fetch", 32'(iREN), 32'd1);
      tick();
      RST     = 1'b0;
      imemREN = 1'b0;
      #4;
      chk("rstmid_iren", 32'(iREN), 32'd0);
      chk("rstmid_iaddr", iaddr, 32'd0);
      chk("rstmid_ihit", 32'(ihit), 32'd0);
`ifdef ICACHE_STATS_EN
      chk("rstmid_hit_count", hit_count, 32'd0);
      chk("rstmid_miss_count", miss_count, 32'd0);
`endif
      exp_hits   = 0;
      exp_misses = 0;
      access(32'h0000_0040, 1, 1'b1);
      check_counts("after_reset");

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
